wbit_ser_rx: RTL and testbench
==============================

WBIT_SER_RX -- requirements
Module: wbit_ser_rx

Interface
REQ-001 SHALL have parameter W, default 4, data word width in bits (W >= 2).
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port RES  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port InS  input  1  serial line; idle high, start bit 0, stop bit 1.
REQ-005 SHALL have port SEN  input  1  bit-sample enable; exactly one line bit is consumed per CLK edge with SEN=1.
REQ-006 SHALL have port DIR  input  1  bit order: 0 = MSB first (shift left), 1 = LSB first (shift right).
REQ-007 SHALL have port ACK  input  1  consumer acknowledge of the held word.
REQ-008 SHALL have port Out  output W  last accepted data word.
REQ-009 SHALL have port VLD  output 1  Out holds an unacknowledged word.
REQ-010 SHALL have port FERR output 1  one-cycle pulse: stop bit sampled as 0.
REQ-011 SHALL have port OVR  output 1  sticky: a word completed while VLD=1 and ACK=0.
REQ-012 SHALL have port BUSY output 1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, DATA, STOP; with SEN=0 no FSM, counter or shift state changes.
REQ-014 IDLE: SEN=1 and InS=0 SHALL enter DATA with bit counter cleared to 0; SEN=1 and InS=1 SHALL remain IDLE.
REQ-015 DATA: each SEN=1 edge SHALL shift InS into the internal shifter (into bit 0 when DIR=0, into bit W-1 when DIR=1) and increment the counter; the edge consuming bit W-1 SHALL enter STOP.
REQ-016 Bit counter SHALL be $clog2(W) bits wide and never wrap within a frame; DIR SHALL be sampled on the start-bit edge and held for the frame.
REQ-017 STOP with SEN=1 and InS=1: if VLD=0 or ACK=1, Out SHALL load the shifter and VLD SHALL be 1 from the next cycle; otherwise Out and VLD SHALL be unchanged and OVR SHALL set; FSM SHALL return to IDLE.
REQ-018 STOP with SEN=1 and InS=0: FERR SHALL pulse high for exactly one cycle, the word SHALL be discarded, Out/VLD unchanged, FSM to IDLE.
REQ-019 ACK=1 with VLD=1 and no simultaneous word load SHALL clear VLD next cycle; ACK with VLD=0 SHALL be ignored.
REQ-020 Latency: VLD SHALL rise one CLK after the stop-bit edge; a full frame costs W+2 SEN cycles.
REQ-021 OVR SHALL clear only on RES.
REQ-022 A start bit SHALL be recognised on the SEN edge immediately after a stop bit (back-to-back frames, no idle gap required).

Reset
REQ-023 RES=1 at a CLK edge SHALL force IDLE, counter 0, shifter 0, Out 0, VLD 0, FERR 0, OVR 0, BUSY 0, overriding SEN, InS and ACK.
REQ-024 RES asserted mid-frame SHALL discard the partial word with no FERR or VLD pulse.

Structure
REQ-025 State encoding (IDLE/DATA/STOP) and constants START_BIT=0, STOP_BIT=1 SHALL live in the shared serial package reused by the transmitter side.
REQ-026 The bidirectional serial-in W-bit shifter SHALL be a sub-module named wbit_sipo (inputs CLK, RES, SEN, DIR, InS; output W-bit word).
REQ-027 Implementation SHALL be 120-400 lines of RTL, single clock domain, no latches.

Verification (W=4, SEN=1 every cycle unless stated)
REQ-028 DIR=0, InS sequence 0,1,1,0,0,1 -> Out=4'b1100, VLD=1 one cycle after stop edge, FERR=0.
REQ-029 DIR=1, InS sequence 0,0,0,1,1,1 -> Out=4'b1100; ACK=1 next cycle -> VLD=0 following cycle.
REQ-030 DIR=0, InS 0,1,0,1,0,0 (bad stop) -> FERR high exactly one cycle, VLD stays 0, Out stays 0.
REQ-031 Two back-to-back frames 1100 then 0011 with ACK=0 -> Out=1100, OVR=1 sticky; repeat with ACK=1 on second stop edge -> Out=0011, VLD stays 1, OVR unchanged.
REQ-032 SEN toggling 1,0 per cycle during frame 1100 -> same Out as REQ-028, BUSY held across gaps; RES=1 after second data bit -> BUSY=0, Out=0, VLD=0 next cycle, subsequent clean frame received correctly.

Source files
------------

// File: rtl/wbit_ser_rx_pkg.sv
// Shared serial-line definitions: frame FSM encoding and line-level bit values,
// common to the receiver and the transmitter side.
package wbit_ser_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } ser_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/wbit_sipo.sv
// Bidirectional serial-in / parallel-out shifter: DIR=0 shifts left into bit 0,
// DIR=1 shifts right into bit W-1. Advances only on SEN.
module wbit_sipo #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         RES,
    input  logic         SEN,
    input  logic         DIR,
    input  logic         InS,
    output logic [W-1:0] word
);

    logic [W-1:0] word_q;
    logic [W-1:0] word_d;

    always_comb begin
        word_d = word_q;
        if (SEN) begin
            if (DIR) word_d = {InS, word_q[W-1:1]};
            else     word_d = {word_q[W-2:0], InS};
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) word_q <= '0;
        else     word_q <= word_d;
    end

    assign word = word_q;

endmodule

// File: rtl/wbit_ser_rx.sv
// W-bit serial frame receiver: start bit, W data bits (MSB- or LSB-first),
// stop bit. Holds the last good word until acknowledged; flags framing and overrun.
module wbit_ser_rx
    import wbit_ser_rx_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         RES,
    input  logic         InS,
    input  logic         SEN,
    input  logic         DIR,
    input  logic         ACK,
    output logic [W-1:0] Out,
    output logic         VLD,
    output logic         FERR,
    output logic         OVR,
    output logic         BUSY,
    output ser_state_e   dbg_state
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    ser_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic [W-1:0]  out_q, out_d;
    logic          vld_q, vld_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          shift_en;
    logic          load;
    logic [W-1:0]  shift_word;

    wbit_sipo #(.W(W)) u_sipo (
        .CLK  (CLK),
        .RES  (RES),
        .SEN  (shift_en),
        .DIR  (dir_q),
        .InS  (InS),
        .word (shift_word)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        out_d    = out_q;
        vld_d    = vld_q;
        ferr_d   = 1'b0;
        ovr_d    = ovr_q;
        shift_en = 1'b0;
        load     = 1'b0;
        case (state_q)
            IDLE: begin
                if (SEN && InS == START_BIT) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    dir_d   = DIR;
                end
            end
            DATA: begin
                if (SEN) begin
                    shift_en = 1'b1;
                    // Counter saturates at the last bit so it never wraps for power-of-two W.
                    if (cnt_q == LAST) state_d = STOP;
                    else               cnt_d   = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (SEN) begin
                    state_d = IDLE;
                    if (InS == STOP_BIT) begin
                        if (!vld_q || ACK) begin
                            load  = 1'b1;
                            out_d = shift_word;
                            vld_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A load in the same cycle wins over the acknowledge of the old word.
        if (ACK && vld_q && !load) vld_d = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            out_q   <= '0;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign Out       = out_q;
    assign VLD       = vld_q;
    assign FERR      = ferr_q;
    assign OVR       = ovr_q;
    assign BUSY      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_wbit_ser_rx.sv
// Bench for wbit_ser_rx: directed frames plus randomized frames with SEN gaps,
// compared against a frame-level reference model.
module tb_wbit_ser_rx;
    import wbit_ser_rx_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         res, ins, sen, dir, ack;
    logic [W-1:0] out_w;
    logic         vld, ferr, ovr, busy;
    ser_state_e   dbg_state;

    wbit_ser_rx #(.W(W)) dut (
        .CLK       (clk),
        .RES       (res),
        .InS       (ins),
        .SEN       (sen),
        .DIR       (dir),
        .ACK       (ack),
        .Out       (out_w),
        .VLD       (vld),
        .FERR      (ferr),
        .OVR       (ovr),
        .BUSY      (busy),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Reference model state (frame level)
    logic [W-1:0] exp_out;
    logic         exp_vld;
    logic         exp_ovr;
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_out = '0;
        exp_vld = 1'b0;
        exp_ovr = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        res = 1'b1;
        ins = $urandom_range(0, 1);
        sen = 1'b1;
        ack = $urandom_range(0, 1);
        step();
        res = 1'b0;
        sen = 1'b0;
        ack = 1'b0;
        ins = 1'b1;
        model_reset();
        check("rst_busy", busy, 0);
        check("rst_out", out_w, 0);
        check("rst_vld", vld, 0);
        check("rst_ferr", ferr, 0);
        check("rst_ovr", ovr, 0);
    endtask

    // Optional SEN=0 gap (InS noise must be ignored), then one consumed bit.
    task automatic send_bit(input logic b, input int gap_lo, input int gap_hi, input logic busy_before);
        int n;
        n = $urandom_range(gap_hi, gap_lo);
        for (int g = 0; g < n; g++) begin
            sen = 1'b0;
            ins = $urandom_range(0, 1);
            step();
            check("gap_busy", busy, busy_before);
        end
        sen = 1'b1;
        ins = b;
        step();
        sen = 1'b0;
        check("bit_busy", busy, 1);
        check("bit_ferr", ferr, 0);
    endtask

    task automatic send_frame(input logic [W-1:0] data, input logic d, input logic stop_ok,
                              input logic ack_stop, input int gap_lo, input int gap_hi);
        logic load;
        ack = 1'b0;
        dir = d;
        send_bit(START_BIT, gap_lo, gap_hi, 1'b0);
        dir = ~d;
        for (int i = 0; i < W; i++)
            send_bit(d ? data[i] : data[W-1-i], gap_lo, gap_hi, 1'b1);
        for (int g = 0; g < $urandom_range(gap_hi, gap_lo); g++) begin
            sen = 1'b0;
            ins = $urandom_range(0, 1);
            step();
            check("stop_gap_busy", busy, 1);
        end
        sen = 1'b1;
        ins = stop_ok ? STOP_BIT : ~STOP_BIT;
        ack = ack_stop;
        step();
        sen = 1'b0;
        ack = 1'b0;
        load = stop_ok && (!exp_vld || ack_stop);
        if (stop_ok && !load) exp_ovr = 1'b1;
        if (load) begin
            exp_out = data;
            exp_q.push_back(data);
        end
        if (ack_stop && exp_vld && !load) exp_vld = 1'b0;
        if (load) exp_vld = 1'b1;
        check("stop_ferr", ferr, !stop_ok);
        check("stop_vld", vld, exp_vld);
        check("stop_out", out_w, exp_q.size() > 0 ? exp_q[$] : exp_out);
        check("stop_ovr", ovr, exp_ovr);
        check("stop_busy", busy, 0);
    endtask

    task automatic idle_cycle(input logic a);
        sen = $urandom_range(0, 1);
        ins = 1'b1;
        ack = a;
        step();
        ack = 1'b0;
        if (a) exp_vld = 1'b0;
        check("idle_ferr", ferr, 0);
        check("idle_vld", vld, exp_vld);
        check("idle_out", out_w, exp_out);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        res = 1'b0; ins = 1'b1; sen = 1'b0; dir = 1'b0; ack = 1'b0;
        model_reset();
        step();
        do_reset();

        // MSB-first 1100
        send_frame(4'b1100, 1'b0, 1'b1, 1'b0, 0, 0);
        idle_cycle(1'b0);

        // LSB-first 1100, then acknowledge
        do_reset();
        send_frame(4'b1100, 1'b1, 1'b1, 1'b0, 0, 0);
        idle_cycle(1'b1);
        idle_cycle(1'b0);

        // Bad stop bit: FERR for one cycle only
        do_reset();
        send_frame(4'b1010, 1'b0, 1'b0, 1'b0, 0, 0);
        idle_cycle(1'b0);

        // Back-to-back frames: overrun, then load-with-ack
        do_reset();
        send_frame(4'b1100, 1'b0, 1'b1, 1'b0, 0, 0);
        send_frame(4'b0011, 1'b0, 1'b1, 1'b0, 0, 0);
        send_frame(4'b1100, 1'b0, 1'b1, 1'b0, 0, 0);
        send_frame(4'b0011, 1'b0, 1'b1, 1'b1, 0, 0);
        idle_cycle(1'b0);

        // SEN toggling, then reset mid-frame, then a clean frame
        do_reset();
        send_frame(4'b1100, 1'b0, 1'b1, 1'b0, 1, 1);
        check("toggle_out", out_w, 4'b1100);
        send_bit(START_BIT, 0, 0, 1'b0);
        send_bit(1'b1, 1, 1, 1'b1);
        send_bit(1'b0, 1, 1, 1'b1);
        do_reset();
        idle_cycle(1'b0);
        send_frame(4'b0110, 1'b1, 1'b1, 1'b0, 0, 1);

        // Randomized frames
        for (int f = 0; f < 60; f++) begin
            send_frame(W'($urandom), 1'($urandom), ($urandom_range(0, 9) != 0),
                       1'($urandom), 0, $urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom));
            if ($urandom_range(0, 19) == 0) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
